// File: rtl/mul_wb_pkg.sv
// Package: mul_wb_pkg
// Shared definitions for the multiplier writeback slice.
//   REG_AW     : register-file address width
//   NREGS      : number of architectural registers
//   XLEN       : writeback data width (product width of mult_pipe)
//   wb_entry_t : one queued writeback {destination register, data}
//   rd_onehot  : decode a destination register into a 1-hot register mask
package mul_wb_pkg;

  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
  localparam int XLEN   = 64;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Turns a destination register number into its bit in a register mask
  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NREGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// Module: mul_wb_fifo
// Circular buffer holding multiplier products until they win the write port.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   push        : request to enqueue push_entry (taken when not full, or when
//                 a pop happens in the same cycle)
//   push_entry  : {rd, data} to enqueue
//   pop         : dequeue head (ignored when empty)
//   head        : oldest entry
//   full, empty : occupancy flags
//   count       : number of stored entries
//   rd_vec      : destination register held in each storage slot
//   valid_vec   : which storage slots currently hold a live entry
module mul_wb_fifo
  import mul_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0][REG_AW-1:0]  rd_vec,
  output logic [DEPTH-1:0]              valid_vec
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;
  logic [PW-1:0]  offs;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full buffer can still take a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slot liveness comes from the pointers alone
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    offs      = '0;
    rd_vec    = '0;
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PW'(i) - rd_ptr;
      rd_vec[i]    = mem[i].rd;
      valid_vec[i] = ({1'b0, offs} < count);
    end
  end

endmodule

// File: rtl/mul_wb_arb.sv
// Module: mul_wb_arb
// Writeback stage behind the pipelined multiplier. Products are queued and
// share the single register-file write port with ALU results; the queue wins
// whenever the ALU is idle or after STARVE_MAX consecutive ALU wins.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   mul_valid/data/rd     : product from the multiplier (cannot be stalled)
//   alu_valid/data/rd     : ALU result offered this cycle
//   alu_ready             : ALU result accepted this cycle (combinational)
//   Wctl, W, WD           : registered register-file write enable/address/data
//   almost_full           : occupancy >= DEPTH-LAT, issue logic must hold start
//   count                 : queue occupancy
//   overflow              : sticky, a product was dropped on a full queue
//   pend_mask             : registers with a write still outstanding
module mul_wb_arb
  import mul_wb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mul_valid,
  input  logic [2*WIDTH-1:0]       mul_data,
  input  logic [REG_AW-1:0]        mul_rd,
  input  logic                     alu_valid,
  input  logic [2*WIDTH-1:0]       alu_data,
  input  logic [REG_AW-1:0]        alu_rd,
  output logic                     alu_ready,
  output logic                     Wctl,
  output logic [REG_AW-1:0]        W,
  output logic [2*WIDTH-1:0]       WD,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [NREGS-1:0]         pend_mask
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t                   push_entry;
  wb_entry_t                   head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [DEPTH-1:0][REG_AW-1:0] rd_vec;
  logic [DEPTH-1:0]            valid_vec;
  logic                        q_win;
  logic                        alu_win;
  logic                        drop;
  logic [SW-1:0]               starve_cnt;

  assign push_entry = '{rd: mul_rd, data: mul_data};

  mul_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (mul_valid),
    .push_entry (push_entry),
    .pop        (q_win),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .rd_vec     (rd_vec),
    .valid_vec  (valid_vec)
  );

  // The queue takes the port when the ALU is idle or has starved it long enough
  always_comb begin
    q_win   = !fifo_empty && (!alu_valid || (starve_cnt == SW'(STARVE_MAX)));
    alu_win = alu_valid && !q_win;
    drop    = mul_valid && fifo_full && !q_win;
  end

  assign alu_ready   = !q_win;
  assign count       = fifo_count;
  assign almost_full = (fifo_count >= CW'(DEPTH - LAT));

  // Output register: winners with rd==0 are consumed without a write and W/WD hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      Wctl     <= 1'b0;
      W        <= '0;
      WD       <= '0;
      overflow <= 1'b0;
    end else begin
      if (q_win) begin
        Wctl <= (head.rd != '0);
        if (head.rd != '0) begin
          W  <= head.rd;
          WD <= head.data;
        end
      end else if (alu_win) begin
        Wctl <= (alu_rd != '0);
        if (alu_rd != '0) begin
          W  <= alu_rd;
          WD <= alu_data;
        end
      end else begin
        Wctl <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Counts ALU wins that bypass a waiting product; any other cycle resets it
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (alu_win && !fifo_empty) begin
      if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Register x0 is never a real hazard, so its bit is forced low
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_vec[i]) pend_mask = pend_mask | rd_onehot(rd_vec[i]);
    end
    if (Wctl) pend_mask = pend_mask | rd_onehot(W);
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_mul_wb_arb.sv
// Testbench: tb_mul_wb_arb
// Drives mul_wb_arb (STARVE_MAX=3) from a vector table, hand-written corner
// sequences and random traffic, comparing every cycle against a queue-based
// reference model. A second instance with STARVE_MAX=8 covers the overflow case.
module tb_mul_wb_arb;
  import mul_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int SM    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_valid, alu_valid;
  logic [63:0] mul_data, alu_data;
  logic [4:0]  mul_rd, alu_rd;
  logic        alu_ready, Wctl, almost_full, overflow;
  logic [4:0]  W;
  logic [63:0] WD;
  logic [2:0]  count;
  logic [31:0] pend_mask;

  logic        mul_valid_b, alu_valid_b;
  logic [63:0] mul_data_b, alu_data_b;
  logic [4:0]  mul_rd_b, alu_rd_b;
  logic        alu_ready_b, Wctl_b, almost_full_b, overflow_b;
  logic [4:0]  W_b;
  logic [63:0] WD_b;
  logic [2:0]  count_b;
  logic [31:0] pend_mask_b;

  int checks = 0;
  int errors = 0;

  // 10-unit clock; inputs change 1 unit after the rising edge, checks at +4
  always #5 clk = ~clk;

  mul_wb_arb #(.WIDTH(32), .DEPTH(DEPTH), .LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_rd(mul_rd),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_rd(alu_rd),
    .alu_ready(alu_ready), .Wctl(Wctl), .W(W), .WD(WD),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .pend_mask(pend_mask)
  );

  mul_wb_arb #(.WIDTH(32), .DEPTH(DEPTH), .LAT(LAT), .STARVE_MAX(8)) dut8 (
    .clk(clk), .rst(rst),
    .mul_valid(mul_valid_b), .mul_data(mul_data_b), .mul_rd(mul_rd_b),
    .alu_valid(alu_valid_b), .alu_data(alu_data_b), .alu_rd(alu_rd_b),
    .alu_ready(alu_ready_b), .Wctl(Wctl_b), .W(W_b), .WD(WD_b),
    .almost_full(almost_full_b), .count(count_b), .overflow(overflow_b),
    .pend_mask(pend_mask_b)
  );

  // Reference model state: the queue itself, starvation run length and output register
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  bit          m_wctl;
  logic [4:0]  m_w;
  logic [63:0] m_wd;
  bit          m_ovf;

  typedef struct {
    bit          r, mv;
    logic [4:0]  mrd;
    logic [63:0] md;
    bit          av;
    logic [4:0]  ard;
    logic [63:0] ad;
    bit          e_wctl;
    logic [4:0]  e_w;
    logic [63:0] e_wd;
    int          e_count;
    bit          e_ready;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vt[13];

  // One comparison: counts it and reports it when the values differ
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelQWin();
    return (mq.size() != 0) && (!alu_valid || m_starve == SM);
  endfunction

  function automatic logic [31:0] modelPend();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) p = p | (32'(1) << mq[i].rd);
    if (m_wctl) p = p | (32'(1) << m_w);
    p[0] = 1'b0;
    return p;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    int   n;
    bit   qw, aw;
    ent_t e;
    if (!rst) begin
      mq.delete();
      m_starve = 0;
      m_wctl   = 0;
      m_w      = '0;
      m_wd     = '0;
      m_ovf    = 0;
    end else begin
      n  = mq.size();
      qw = modelQWin();
      aw = alu_valid && !qw;
      if (qw) begin
        e = mq.pop_front();
        m_wctl = (e.rd != 0);
        if (e.rd != 0) begin m_w = e.rd; m_wd = e.data; end
      end else if (aw) begin
        m_wctl = (alu_rd != 0);
        if (alu_rd != 0) begin m_w = alu_rd; m_wd = alu_data; end
      end else begin
        m_wctl = 0;
      end
      if (mul_valid) begin
        if (n == DEPTH && !qw) m_ovf = 1;
        else begin
          e.rd = mul_rd;
          e.data = mul_data;
          mq.push_back(e);
        end
      end
      if (aw && n != 0) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else m_starve = 0;
    end
  endtask

  task automatic compareModel();
    checkOutput("alu_ready", alu_ready, !modelQWin());
    checkOutput("Wctl", Wctl, m_wctl);
    checkOutput("W", W, m_w);
    checkOutput("WD", WD, m_wd);
    checkOutput("count", count, mq.size());
    checkOutput("almost_full", almost_full, mq.size() >= DEPTH - LAT);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("pend_mask", pend_mask, modelPend());
  endtask

  // Drives the main instance for one cycle and compares it with the model before the edge
  task automatic applyStimulus(input bit r, input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                               input bit av, input logic [4:0] ard, input logic [63:0] ad);
    rst       = r;
    mul_valid = mv;
    mul_rd    = mrd;
    mul_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    #3;
    compareModel();
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
  endtask

  // Safety net so the run always ends
  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, vector table, corner sequences, random traffic
  initial begin
    logic [4:0]  got_rd[8];
    logic [63:0] got_wd[8];
    int          n_got;
    logic [4:0]  exp_rd[5];

    mul_valid_b = 0; mul_rd_b = '0; mul_data_b = '0;
    alu_valid_b = 0; alu_rd_b = '0; alu_data_b = '0;

    // Reset edge with both sources active: inputs must be ignored
    rst = 0; mul_valid = 1; mul_rd = 5'd9; mul_data = 64'hFFFF;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 64'hEEEE;
    @(posedge clk);
    modelStep();
    #1;

    vt[0]  = '{1,0,5'd0,64'h0,   0,5'd0, 64'h0,   0,5'd0, 64'h0,   0,1,32'h0};
    vt[1]  = '{1,1,5'd5,64'h1234,0,5'd0, 64'h0,   0,5'd0, 64'h0,   0,1,32'h0};
    vt[2]  = '{1,0,5'd0,64'h0,   0,5'd0, 64'h0,   0,5'd0, 64'h0,   1,0,32'h20};
    vt[3]  = '{1,0,5'd0,64'h0,   0,5'd0, 64'h0,   1,5'd5, 64'h1234,0,1,32'h20};
    vt[4]  = '{1,0,5'd0,64'h0,   0,5'd0, 64'h0,   0,5'd5, 64'h1234,0,1,32'h0};
    vt[5]  = '{1,1,5'd7,64'h77,  1,5'd10,64'hA0,  0,5'd5, 64'h1234,0,1,32'h0};
    vt[6]  = '{1,0,5'd0,64'h0,   1,5'd11,64'hA1,  1,5'd10,64'hA0,  1,1,32'h480};
    vt[7]  = '{1,0,5'd0,64'h0,   1,5'd12,64'hA2,  1,5'd11,64'hA1,  1,1,32'h880};
    vt[8]  = '{1,0,5'd0,64'h0,   1,5'd13,64'hA3,  1,5'd12,64'hA2,  1,1,32'h1080};
    vt[9]  = '{1,0,5'd0,64'h0,   1,5'd14,64'hA4,  1,5'd13,64'hA3,  1,0,32'h2080};
    vt[10] = '{1,0,5'd0,64'h0,   1,5'd15,64'hA5,  1,5'd7, 64'h77,  0,1,32'h80};
    vt[11] = '{1,0,5'd0,64'h0,   0,5'd0, 64'h0,   1,5'd15,64'hA5,  0,1,32'h8000};
    vt[12] = '{1,0,5'd0,64'h0,   0,5'd0, 64'h0,   0,5'd15,64'hA5,  0,1,32'h0};

    // Table: reset state, single-product latency and the starvation limit
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vt[i].r, vt[i].mv, vt[i].mrd, vt[i].md, vt[i].av, vt[i].ard, vt[i].ad);
      checkOutput($sformatf("vec%0d_Wctl", i), Wctl, vt[i].e_wctl);
      checkOutput($sformatf("vec%0d_W", i), W, vt[i].e_w);
      checkOutput($sformatf("vec%0d_WD", i), WD, vt[i].e_wd);
      checkOutput($sformatf("vec%0d_count", i), count, vt[i].e_count);
      checkOutput($sformatf("vec%0d_alu_ready", i), alu_ready, vt[i].e_ready);
      checkOutput($sformatf("vec%0d_pend", i), pend_mask, vt[i].e_pend);
      tick();
    end

    // Overflow on the STARVE_MAX=8 instance: rd=5 must be dropped
    for (int k = 0; k < 5; k++) begin
      mul_valid_b = 1; mul_rd_b = 5'(k + 1); mul_data_b = 64'h100 + 64'(k);
      alu_valid_b = 1; alu_rd_b = 5'd20; alu_data_b = 64'hCC;
      idleCycle();
      tick();
    end
    mul_valid_b = 0; alu_valid_b = 0;
    idleCycle();
    checkOutput("ovf_count", count_b, 3'd4);
    checkOutput("ovf_flag", overflow_b, 1'b1);
    checkOutput("ovf_almost_full", almost_full_b, 1'b1);
    tick();
    n_got = 0;
    for (int c = 0; c < 10; c++) begin
      idleCycle();
      if (Wctl_b && n_got < 8) begin
        got_rd[n_got] = W_b; got_wd[n_got] = WD_b; n_got++;
      end
      tick();
    end
    checkOutput("ovf_nwrites", n_got, 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("ovf_rd%0d", k), (k < n_got) ? got_rd[k] : 5'd0, 5'(k + 1));
      checkOutput($sformatf("ovf_wd%0d", k), (k < n_got) ? got_wd[k] : 64'h0, 64'h100 + 64'(k));
    end
    checkOutput("ovf_sticky", overflow_b, 1'b1);

    // Full queue with simultaneous push and pop keeps count and order
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 5'(k + 1), 64'h200 + 64'(k), 1, 5'd20, 64'hBB);
      tick();
    end
    applyStimulus(1, 1, 5'd9, 64'h209, 0, 5'd0, 64'h0);
    checkOutput("pp_count_before", count, 3'd4);
    tick();
    idleCycle();
    checkOutput("pp_count_after", count, 3'd4);
    checkOutput("pp_overflow", overflow, 1'b0);
    exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
    n_got = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) idleCycle();
      if (Wctl && n_got < 8) begin got_rd[n_got] = W; n_got++; end
      tick();
    end
    checkOutput("pp_nwrites", n_got, 5);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("pp_rd%0d", k), (k < n_got) ? got_rd[k] : 5'd0, exp_rd[k]);

    // rd=0 product is consumed without a write
    applyStimulus(1, 1, 5'd0, 64'hDEAD, 0, 5'd0, 64'h0);
    tick();
    idleCycle();
    checkOutput("rd0_count_queued", count, 3'd1);
    tick();
    idleCycle();
    checkOutput("rd0_count_drained", count, 3'd0);
    checkOutput("rd0_no_write", Wctl, 1'b0);
    tick();

    // Reset while three products are queued discards all of them
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 5'(k + 1), 64'h300 + 64'(k), 1, 5'd21, 64'hDD);
      tick();
    end
    applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    checkOutput("mrst_count_before", count, 3'd3);
    tick();
    for (int c = 0; c < 4; c++) begin
      idleCycle();
      checkOutput($sformatf("mrst_count%0d", c), count, 3'd0);
      checkOutput($sformatf("mrst_wctl%0d", c), Wctl, 1'b0);
      tick();
    end

    // Random traffic against the model, with occasional resets
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 63) != 0,
                    $urandom_range(0, 9) < 6,
                    5'($urandom_range(0, 31)),
                    {$urandom, $urandom},
                    $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 31)),
                    {$urandom, $urandom});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
